// File: rtl/ccm_accumulator.sv
// CCM accumulator: signs and sums the nine LUT products per output channel, clamps to 8 bits, 3-cycle latency.
// Optional `CCM_SAT_CNT_EN adds sat_count, the number of clamped pixels in the previous frame.
module ccm_accumulator #(
  parameter logic [8:0] SIGN_MASK = 9'b000000000,
  parameter int         PROD_W    = 12,
  parameter int         SUM_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_de,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic [PROD_W-1:0] p_rr,
  input  logic [PROD_W-1:0] p_rg,
  input  logic [PROD_W-1:0] p_rb,
  input  logic [PROD_W-1:0] p_gr,
  input  logic [PROD_W-1:0] p_gg,
  input  logic [PROD_W-1:0] p_gb,
  input  logic [PROD_W-1:0] p_br,
  input  logic [PROD_W-1:0] p_bg,
  input  logic [PROD_W-1:0] p_bb,
  input  logic [7:0]        in_r,
  input  logic [7:0]        in_g,
  input  logic [7:0]        in_b,
  input  logic              bypass,
  output logic              out_de,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b
`ifdef CCM_SAT_CNT_EN
  ,
  output logic [23:0]       sat_count
`endif
);

  logic [8:0][PROD_W-1:0] prod_in;
  logic [8:0][PROD_W-1:0] s1_prod;
  logic [2:0][7:0]        s1_raw;
  logic [2:0][7:0]        s2_raw;
  logic                   s1_de, s1_hs, s1_vs, s1_byp;
  logic                   s2_de, s2_hs, s2_vs, s2_byp;
  logic                   bypass_active;
  logic                   vs_rise;
  logic                   mode_next;
  logic signed [SUM_W-1:0] sum    [3];
  logic signed [SUM_W-1:0] s2_sum [3];

  function automatic logic signed [SUM_W-1:0] signed_term(input logic [PROD_W-1:0] mag,
                                                          input logic neg);
    logic signed [SUM_W-1:0] ext;
    ext = $signed({{(SUM_W-PROD_W){1'b0}}, mag});
    return neg ? -ext : ext;
  endfunction

  function automatic logic is_clip(input logic signed [SUM_W-1:0] s);
    return s[SUM_W-1] | (s > SUM_W'(255));
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1])
      return 8'd0;
    else if (s > SUM_W'(255))
      return 8'hFF;
    return s[7:0];
  endfunction

  // Product index matches SIGN_MASK bit order: 8 = rr ... 0 = bb
  assign prod_in = {p_rr, p_rg, p_rb, p_gr, p_gg, p_gb, p_br, p_bg, p_bb};

  // The mode travels with each pixel so the vsync pixel already uses the newly latched mode
  assign vs_rise   = in_vsync & ~s1_vs;
  assign mode_next = vs_rise ? bypass : bypass_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_prod       <= '0;
      s1_raw        <= '0;
      s1_de         <= 1'b0;
      s1_hs         <= 1'b0;
      s1_vs         <= 1'b0;
      s1_byp        <= 1'b0;
      bypass_active <= 1'b0;
    end else begin
      s1_prod       <= prod_in;
      s1_raw        <= {in_b, in_g, in_r};
      s1_de         <= in_de;
      s1_hs         <= in_hsync;
      s1_vs         <= in_vsync;
      s1_byp        <= mode_next;
      bypass_active <= mode_next;
    end
  end

  always_comb begin
    sum[0] = signed_term(s1_prod[8], SIGN_MASK[8]) + signed_term(s1_prod[5], SIGN_MASK[5])
           + signed_term(s1_prod[2], SIGN_MASK[2]);
    sum[1] = signed_term(s1_prod[7], SIGN_MASK[7]) + signed_term(s1_prod[4], SIGN_MASK[4])
           + signed_term(s1_prod[1], SIGN_MASK[1]);
    sum[2] = signed_term(s1_prod[6], SIGN_MASK[6]) + signed_term(s1_prod[3], SIGN_MASK[3])
           + signed_term(s1_prod[0], SIGN_MASK[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int y = 0; y < 3; y++) s2_sum[y] <= '0;
      s2_raw <= '0;
      s2_de  <= 1'b0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
      s2_byp <= 1'b0;
    end else begin
      for (int y = 0; y < 3; y++) s2_sum[y] <= sum[y];
      s2_raw <= s1_raw;
      s2_de  <= s1_de;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_byp <= s1_byp;
    end
  end

  // Blanking samples output black regardless of mode
  always_ff @(posedge clk) begin
    if (rst) begin
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_r     <= 8'd0;
      out_g     <= 8'd0;
      out_b     <= 8'd0;
    end else begin
      out_de    <= s2_de;
      out_hsync <= s2_hs;
      out_vsync <= s2_vs;
      if (!s2_de) begin
        out_r <= 8'd0;
        out_g <= 8'd0;
        out_b <= 8'd0;
      end else if (s2_byp) begin
        out_r <= s2_raw[0];
        out_g <= s2_raw[1];
        out_b <= s2_raw[2];
      end else begin
        out_r <= clamp8(s2_sum[0]);
        out_g <= clamp8(s2_sum[1]);
        out_b <= clamp8(s2_sum[2]);
      end
    end
  end

`ifdef CCM_SAT_CNT_EN
  logic [23:0] sat_run;
  logic        sat_pix;

  assign sat_pix = s2_de & ~s2_byp &
                   (is_clip(s2_sum[0]) | is_clip(s2_sum[1]) | is_clip(s2_sum[2]));

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_run   <= 24'd0;
      sat_count <= 24'd0;
    end else if (vs_rise) begin
      sat_count <= sat_run;
      sat_run   <= 24'd0;
    end else if (sat_pix && (sat_run != 24'hFFFFFF)) begin
      sat_run <= sat_run + 24'd1;
    end
  end
`endif

endmodule
